// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
// The hazard unit taps md_stall; mfhi/mflo read hi/lo.
interface md_unit_if;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdop, a, b,
        input  busy, md_stall, hi, lo
    );

    modport slave (
        input  start, mdop, a, b,
        output busy, md_stall, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Fixed-latency multiply/divide unit with HI/LO registers.
// The product/quotient is formed from the latched operands and registered on the last busy edge.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic     clk,
    input logic     reset,
    md_unit_if.slave md
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_e;

    state_e      state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] a_q, b_q, hi_q, lo_q;
    logic [2:0]  op_q;
    logic        busy_q;

    logic signed [63:0] sa, sb, sprod;
    logic [63:0] uprod;
    logic        div_sgn;
    logic [31:0] ua, ub, dvs, uq, ur, quo, rem;
    logic [31:0] hi_d, lo_d;
    logic        wr_d;

    assign sa    = $signed({{32{a_q[31]}}, a_q});
    assign sb    = $signed({{32{b_q[31]}}, b_q});
    assign sprod = sa * sb;
    assign uprod = {32'd0, a_q} * {32'd0, b_q};

    // Signed divide works on magnitudes so 0x80000000 / -1 wraps without a trap.
    assign div_sgn = (op_q == OP_DIV);
    assign ua  = (div_sgn && a_q[31]) ? -a_q : a_q;
    assign ub  = (div_sgn && b_q[31]) ? -b_q : b_q;
    assign dvs = (ub == 32'd0) ? 32'd1 : ub;
    assign uq  = ua / dvs;
    assign ur  = ua % dvs;
    assign quo = (div_sgn && (a_q[31] ^ b_q[31])) ? -uq : uq;
    assign rem = (div_sgn && a_q[31]) ? -ur : ur;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        wr_d = 1'b0;
        unique case (op_q)
            OP_MULT: begin
                {hi_d, lo_d} = sprod;
                wr_d = 1'b1;
            end
            OP_MULTU: begin
                {hi_d, lo_d} = uprod;
                wr_d = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                hi_d = rem;
                lo_d = quo;
                wr_d = (b_q != 32'd0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (md.start) begin
                        unique case (md.mdop)
                            OP_MULT, OP_MULTU: begin
                                a_q     <= md.a;
                                b_q     <= md.b;
                                op_q    <= md.mdop;
                                cnt_q   <= CW'(MULT_CYCLES);
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_q     <= md.a;
                                b_q     <= md.b;
                                op_q    <= md.mdop;
                                cnt_q   <= CW'(DIV_CYCLES);
                                state_q <= RUN;
                                busy_q  <= 1'b1;
                            end
                            OP_MTHI: hi_q <= md.a;
                            OP_MTLO: lo_q <= md.a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    if (cnt_q == CW'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                        if (wr_d) begin
                            hi_q <= hi_d;
                            lo_q <= lo_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md.busy     = busy_q;
    assign md.md_stall = busy_q | (md.start && md.mdop >= OP_MULT && md.mdop <= OP_DIVU);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;
endmodule
